// File: rtl/cache_ctrl_pkg.sv
// Shared types and defaults for the direct-mapped write-through cache controller.
package cache_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FILL_RD  = 2'd1,
    FILL_CAP = 2'd2,
    WRITE    = 2'd3
  } state_e;

  localparam int A_WIDTH_DEF  = 8;
  localparam int D_WIDTH_DEF  = 8;
  localparam int IDX_BITS_DEF = 2;

  localparam int           CNT_W   = 8;
  localparam logic [CNT_W-1:0] CNT_MAX = 8'hFF;

endpackage

// File: rtl/cache_line_store.sv
// One-word-per-line valid/tag/data store with combinational lookup and
// synchronous fill, data update, flush and reset.
module cache_line_store
  import cache_ctrl_pkg::*;
#(
  parameter int A_WIDTH  = A_WIDTH_DEF,
  parameter int D_WIDTH  = D_WIDTH_DEF,
  parameter int IDX_BITS = IDX_BITS_DEF
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               flush_i,
  input  logic               fill_i,
  input  logic               upd_i,
  input  logic [A_WIDTH-1:0] addr_i,
  input  logic [D_WIDTH-1:0] wdata_i,
  output logic               hit_o,
  output logic [D_WIDTH-1:0] rdata_o
);

  localparam int TAG_W  = A_WIDTH - IDX_BITS;
  localparam int NLINES = 1 << IDX_BITS;

  logic               valid_q [NLINES];
  logic [TAG_W-1:0]   tag_q   [NLINES];
  logic [D_WIDTH-1:0] data_q  [NLINES];

  logic [IDX_BITS-1:0] idx;
  logic [TAG_W-1:0]    tag;

  assign idx = addr_i[IDX_BITS-1:0];
  assign tag = addr_i[A_WIDTH-1:IDX_BITS];

  assign hit_o   = valid_q[idx] && (tag_q[idx] == tag);
  assign rdata_o = data_q[idx];

  generate
    for (genvar gi = 0; gi < NLINES; gi++) begin : g_line
      always_ff @(posedge clk) begin
        if (clr) begin
          valid_q[gi] <= 1'b0;
          tag_q[gi]   <= '0;
          data_q[gi]  <= '0;
        end else if (flush_i) begin
          valid_q[gi] <= 1'b0;
        end else if (fill_i && (idx == IDX_BITS'(gi))) begin
          valid_q[gi] <= 1'b1;
          tag_q[gi]   <= tag;
          data_q[gi]  <= wdata_i;
        end else if (upd_i && (idx == IDX_BITS'(gi))) begin
          // Write hit keeps valid/tag; only the word changes.
          data_q[gi]  <= wdata_i;
        end
      end
    end
  endgenerate

endmodule

// File: rtl/cache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate cache controller between
// the CPU and a 1-cycle-latency RAM, with saturating hit/miss counters.
module cache_ctrl
  import cache_ctrl_pkg::*;
#(
  parameter int A_WIDTH  = A_WIDTH_DEF,
  parameter int D_WIDTH  = D_WIDTH_DEF,
  parameter int IDX_BITS = IDX_BITS_DEF
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               cpu_req,
  input  logic               cpu_we,
  input  logic [A_WIDTH-1:0] cpu_addr,
  input  logic [D_WIDTH-1:0] cpu_wdata,
  output logic [D_WIDTH-1:0] cpu_rdata,
  output logic               cpu_ready,
  input  logic               cache_flush,
  output logic               busy,
  output logic               mem_enab,
  output logic               mem_rw,
  output logic [A_WIDTH-1:0] mem_addr,
  output logic [D_WIDTH-1:0] mem_wdata,
  input  logic [D_WIDTH-1:0] mem_rdata,
  output logic [CNT_W-1:0]   hit_cnt,
  output logic [CNT_W-1:0]   miss_cnt
);

  state_e state_q, state_d;

  logic [A_WIDTH-1:0] addr_q;
  logic               we_q;
  logic [D_WIDTH-1:0] wdata_q;
  logic [D_WIDTH-1:0] rdata_q, rdata_d;
  logic               ready_q, ready_d;
  logic [CNT_W-1:0]   hit_cnt_q, miss_cnt_q;

  logic               latch_en, hit_inc, miss_inc;
  logic               flush, fill_en, upd_en;
  logic               line_hit;
  logic [A_WIDTH-1:0] line_addr;
  logic [D_WIDTH-1:0] line_rdata, line_wdata;

  // IDLE looks up the live request; later states work on the latched one.
  assign line_addr  = (state_q == IDLE) ? cpu_addr : addr_q;
  assign line_wdata = (state_q == FILL_CAP) ? mem_rdata : wdata_q;

  cache_line_store #(
    .A_WIDTH (A_WIDTH),
    .D_WIDTH (D_WIDTH),
    .IDX_BITS(IDX_BITS)
  ) u_lines (
    .clk    (clk),
    .clr    (clr),
    .flush_i(flush),
    .fill_i (fill_en),
    .upd_i  (upd_en),
    .addr_i (line_addr),
    .wdata_i(line_wdata),
    .hit_o  (line_hit),
    .rdata_o(line_rdata)
  );

  always_comb begin
    state_d  = state_q;
    rdata_d  = rdata_q;
    ready_d  = 1'b0;
    latch_en = 1'b0;
    hit_inc  = 1'b0;
    miss_inc = 1'b0;
    flush    = 1'b0;
    fill_en  = 1'b0;
    upd_en   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cache_flush) begin
          flush = 1'b1;
        end else if (cpu_req) begin
          latch_en = 1'b1;
          if (cpu_we) begin
            state_d = WRITE;
          end else if (line_hit) begin
            rdata_d = line_rdata;
            ready_d = 1'b1;
            hit_inc = 1'b1;
          end else begin
            miss_inc = 1'b1;
            state_d  = FILL_RD;
          end
        end
      end
      FILL_RD: state_d = FILL_CAP;
      FILL_CAP: begin
        fill_en = 1'b1;
        rdata_d = mem_rdata;
        ready_d = 1'b1;
        state_d = IDLE;
      end
      WRITE: begin
        upd_en  = line_hit;
        ready_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      ready_q    <= 1'b0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
      ready_q <= ready_d;
      if (latch_en) begin
        addr_q  <= cpu_addr;
        we_q    <= cpu_we;
        wdata_q <= cpu_wdata;
      end
      if (hit_inc && (hit_cnt_q != CNT_MAX)) hit_cnt_q <= hit_cnt_q + 1'b1;
      if (miss_inc && (miss_cnt_q != CNT_MAX)) miss_cnt_q <= miss_cnt_q + 1'b1;
    end
  end

  // RAM pins are a pure decode of state and latched request.
  assign mem_enab  = (state_q == FILL_RD) || (state_q == WRITE);
  assign mem_rw    = (state_q == WRITE) && we_q;
  assign mem_addr  = mem_enab ? addr_q : '0;
  assign mem_wdata = (state_q == WRITE) ? wdata_q : '0;

  assign busy      = (state_q != IDLE);
  assign cpu_ready = ready_q;
  assign cpu_rdata = rdata_q;
  assign hit_cnt   = hit_cnt_q;
  assign miss_cnt  = miss_cnt_q;

endmodule

// File: tb/tb_cache_ctrl.sv
// Scoreboard bench for cache_ctrl with a 1-cycle-latency RAM model.
module tb_cache_ctrl;

  logic       clk = 1'b0;
  logic       clr;
  logic       cpu_req, cpu_we, cache_flush;
  logic [7:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic       cpu_ready, busy;
  logic       mem_enab, mem_rw;
  logic [7:0] mem_addr, mem_wdata, mem_rdata;
  logic [7:0] hit_cnt, miss_cnt;

  cache_ctrl dut (
    .clk        (clk),
    .clr        (clr),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_rdata  (cpu_rdata),
    .cpu_ready  (cpu_ready),
    .cache_flush(cache_flush),
    .busy       (busy),
    .mem_enab   (mem_enab),
    .mem_rw     (mem_rw),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .hit_cnt    (hit_cnt),
    .miss_cnt   (miss_cnt)
  );

  always #5 clk = ~clk;

  // RAM: registered read data, write on enab&rw.
  logic [7:0] ram [256];
  always @(posedge clk) begin
    if (mem_enab) begin
      if (mem_rw) ram[mem_addr] <= mem_wdata;
      else        mem_rdata    <= ram[mem_addr];
    end
  end

  // Reference state
  logic [7:0] ref_mem [256];
  logic       mv [4];
  logic [5:0] mt [4];
  int         exp_hit, exp_miss;
  logic [7:0] last_rdata;
  logic [7:0] sb_q [$];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) mv[i] = 1'b0;
    exp_hit    = 0;
    exp_miss   = 0;
    last_rdata = 8'h00;
  endtask

  task automatic do_req(input logic we, input logic [7:0] addr, input logic [7:0] wd);
    int         exp_lat, exp_enab, cyc, enab_seen;
    logic       hit, done;
    logic [1:0] idx;
    logic [7:0] exp_rd, got;
    idx = addr[1:0];
    hit = mv[idx] && (mt[idx] == addr[7:2]);
    if (we) begin
      exp_lat = 2; exp_enab = 1; exp_rd = last_rdata;
    end else if (hit) begin
      exp_lat = 1; exp_enab = 0; exp_rd = ref_mem[addr];
      if (exp_hit < 255) exp_hit++;
    end else begin
      exp_lat = 3; exp_enab = 1; exp_rd = ref_mem[addr];
      if (exp_miss < 255) exp_miss++;
      mv[idx] = 1'b1; mt[idx] = addr[7:2];
    end
    sb_q.push_back(exp_rd);

    @(negedge clk);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd;
    @(posedge clk);
    #1;
    cpu_req = 1'b0;
    enab_seen = 0;
    done = 1'b0;
    for (cyc = 1; cyc <= 8 && !done; cyc++) begin
      @(negedge clk);
      if (mem_enab) begin
        enab_seen++;
        check("mem_rw", mem_rw, we);
        check("mem_addr", mem_addr, addr);
        if (we) check("mem_wdata", mem_wdata, wd);
      end
      if (cpu_ready) begin
        got = sb_q.pop_front();
        check("rdata", cpu_rdata, got);
        check("latency", cyc, exp_lat);
        done = 1'b1;
      end
    end
    if (!done) begin
      check("ready_timeout", 0, 1);
      void'(sb_q.pop_front());
    end
    check("enab_cycles", enab_seen, exp_enab);
    @(negedge clk);
    check("ready_pulse", cpu_ready, 1'b0);
    if (we) ref_mem[addr] = wd;
    last_rdata = exp_rd;
    check("hit_cnt", hit_cnt, exp_hit);
    check("miss_cnt", miss_cnt, exp_miss);
    $display("req we=%0d addr=0x%02h wd=0x%02h rdata=0x%02h hit_cnt=%0d miss_cnt=%0d",
             we, addr, wd, cpu_rdata, hit_cnt, miss_cnt);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      ram[i]     = 8'(i * 7 + 1);
      ref_mem[i] = 8'(i * 7 + 1);
    end
    ram[8'h03] = 8'hEF; ref_mem[8'h03] = 8'hEF;
    ram[8'h07] = 8'h99; ref_mem[8'h07] = 8'h99;
    for (int i = 0; i < 4; i++) mt[i] = '0;
    model_reset();
    clr = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0; cache_flush = 1'b0;
    repeat (3) @(posedge clk);
    #1 clr = 1'b0;
    @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_ready", cpu_ready, 1'b0);
    check("rst_rdata", cpu_rdata, 8'h00);
    check("rst_hit", hit_cnt, 8'h00);
    check("rst_miss", miss_cnt, 8'h00);
    check("rst_enab", mem_enab, 1'b0);
    check("rst_maddr", mem_addr, 8'h00);

    do_req(1'b0, 8'h03, 8'h00);  // miss 0xEF
    do_req(1'b0, 8'h03, 8'h00);  // hit
    do_req(1'b1, 8'h03, 8'hA5);  // write hit
    do_req(1'b0, 8'h03, 8'h00);  // hit 0xA5
    do_req(1'b0, 8'h07, 8'h00);  // miss, evicts 0x03
    do_req(1'b0, 8'h03, 8'h00);  // miss again
    do_req(1'b1, 8'h05, 8'h3C);  // write miss, no allocate
    do_req(1'b0, 8'h05, 8'h00);  // miss, reads 0x3C
    do_req(1'b0, 8'hFF, 8'h00);  // top address
    do_req(1'b0, 8'hFF, 8'h00);

    // Flush and request together: flush wins, held request accepted next.
    @(negedge clk);
    cache_flush = 1'b1; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h03;
    @(posedge clk);
    #1;
    cache_flush = 1'b0;
    check("flush_busy", busy, 1'b0);
    check("flush_ready", cpu_ready, 1'b0);
    for (int i = 0; i < 4; i++) mv[i] = 1'b0;
    do_req(1'b0, 8'h03, 8'h00);  // must miss

    // Reset during FILL_CAP
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h06;
    @(posedge clk);
    #1 cpu_req = 1'b0;
    @(negedge clk);
    check("abort_fillrd_enab", mem_enab, 1'b1);
    @(negedge clk);
    clr = 1'b1;
    @(posedge clk);
    #1 clr = 1'b0;
    model_reset();
    check("abort_busy", busy, 1'b0);
    check("abort_hit", hit_cnt, 8'h00);
    check("abort_miss", miss_cnt, 8'h00);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("abort_no_ready", cpu_ready, 1'b0);
    end
    do_req(1'b0, 8'h06, 8'h00);  // misses after reset

    // Saturation of the hit counter
    for (int i = 0; i < 258; i++) do_req(1'b0, 8'h06, 8'h00);
    check("hit_sat", hit_cnt, 8'hFF);
    do_req(1'b1, 8'h06, 8'h11);  // writes do not count
    do_req(1'b0, 8'h06, 8'h00);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
